// File: rtl/hdmi_read_scheduler.sv
// Frame-buffer read sequencer for the HDMI output pixel FIFO.
// Turns output-core timing pulses into throttled burst read requests.
module hdmi_read_scheduler #(
    parameter int ADDR_WIDTH          = 32,
    parameter int NUM_BYTES_PER_PIXEL = 4,
    parameter int BURST_BYTES         = 256,
    parameter int PREFETCH_BURSTS     = 2,
    parameter int FIFO_DEPTH_WORDS    = 512,
    localparam int BURST_LOG = $clog2(BURST_BYTES),
    localparam int LW        = BURST_LOG + 1,
    localparam int FW        = $clog2(FIFO_DEPTH_WORDS) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] frame_base,
    input  logic [15:0]           line_stride,
    input  logic [10:0]           hres,
    input  logic                  read_go,
    input  logic                  read_next_line,
    input  logic                  read_next_chunk,
    input  logic                  read_done,
    input  logic [FW-1:0]         fifo_words,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [LW-1:0]         req_len,
    output logic                  busy,
    output logic [10:0]           line_index,
    output logic                  line_underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [15:0]           r_stride;
    logic [10:0]           r_hres;
    logic [ADDR_WIDTH-1:0] r_line_addr;
    logic [10:0]           r_line_index;
    logic [15:0]           r_issued;
    logic [15:0]           r_credits;
    logic [15:0]           r_bursts;
    logic [LW-1:0]         r_last_len;
    logic                  r_underrun;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [LW-1:0]         r_req_len;
    logic                  r_pend_done;
    logic                  r_pend_line;
    logic                  r_pend_chunk;
    logic                  r_pend_abort;

    logic [15:0]           w_line_bytes;
    logic [15:0]           w_bursts_calc;
    logic [BURST_LOG-1:0]  w_rem;
    logic [LW-1:0]         w_last_calc;
    logic                  w_fifo_ok;
    logic                  w_can_issue;
    logic                  w_final;
    logic                  w_done;
    logic                  w_line;
    logic                  w_chunk;
    logic                  w_go;

    assign w_line_bytes  = 16'(32'(r_hres) * NUM_BYTES_PER_PIXEL);
    assign w_bursts_calc = 16'((32'(w_line_bytes) + BURST_BYTES - 1) >> BURST_LOG);
    assign w_rem         = w_line_bytes[BURST_LOG-1:0];
    assign w_last_calc   = (w_rem == '0) ? LW'(BURST_BYTES) : LW'(w_rem);

    // Free space is checked by addition so a bogus occupancy never wraps.
    assign w_fifo_ok   = (32'(fifo_words) + 32'(BURST_BYTES / 4))
                         <= 32'(FIFO_DEPTH_WORDS);
    assign w_can_issue = (r_issued < r_bursts) && (r_credits != '0) && w_fifo_ok;
    assign w_final     = ((r_issued + 16'd1) == r_bursts);

    // Events held back during HOLD are merged with live ones in ISSUE.
    assign w_done  = read_done | r_pend_done;
    assign w_line  = read_next_line | r_pend_line;
    assign w_chunk = read_next_chunk | r_pend_chunk;
    assign w_go    = start & read_go;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = start ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                if (!start || w_done) w_next = S_IDLE;
                else if (w_line || w_chunk) w_next = S_ISSUE;
                else if (w_can_issue) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (req_ready) begin
                    w_next = (!start || r_pend_abort) ? S_IDLE : S_ISSUE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid = (r_state == S_HOLD);
        busy      = (r_state != S_IDLE);
    end

    assign req_addr      = r_req_addr;
    assign req_len       = r_req_len;
    assign line_index    = r_line_index;
    assign line_underrun = r_underrun;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_base       <= '0;
            r_stride     <= '0;
            r_hres       <= '0;
            r_line_addr  <= '0;
            r_line_index <= '0;
            r_issued     <= '0;
            r_credits    <= '0;
            r_bursts     <= '0;
            r_last_len   <= '0;
            r_underrun   <= 1'b0;
            r_req_addr   <= '0;
            r_req_len    <= '0;
            r_pend_done  <= 1'b0;
            r_pend_line  <= 1'b0;
            r_pend_chunk <= 1'b0;
            r_pend_abort <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_pend_done  <= 1'b0;
                    r_pend_line  <= 1'b0;
                    r_pend_chunk <= 1'b0;
                    r_pend_abort <= 1'b0;
                    if (w_go) begin
                        r_base   <= frame_base;
                        r_stride <= line_stride;
                        r_hres   <= hres;
                    end
                end
                S_LOAD: begin
                    r_line_addr  <= r_base;
                    r_line_index <= '0;
                    r_issued     <= '0;
                    r_credits    <= 16'(PREFETCH_BURSTS);
                    r_underrun   <= 1'b0;
                    r_bursts     <= w_bursts_calc;
                    r_last_len   <= w_last_calc;
                end
                S_ISSUE: begin
                    r_pend_done  <= 1'b0;
                    r_pend_line  <= 1'b0;
                    r_pend_chunk <= 1'b0;
                    r_pend_abort <= 1'b0;
                    if (start && !w_done) begin
                        if (w_line) begin
                            if (r_issued < r_bursts) r_underrun <= 1'b1;
                            r_line_addr  <= r_line_addr + ADDR_WIDTH'(r_stride);
                            r_line_index <= r_line_index + 11'd1;
                            r_issued     <= '0;
                            r_credits    <= 16'(PREFETCH_BURSTS);
                        end else if (w_chunk) begin
                            if (r_credits < r_bursts) r_credits <= r_credits + 16'd1;
                        end else if (w_can_issue) begin
                            r_req_addr <= r_line_addr
                                        + (ADDR_WIDTH'(r_issued) << BURST_LOG);
                            r_req_len  <= w_final ? r_last_len : LW'(BURST_BYTES);
                        end
                    end
                end
                S_HOLD: begin
                    if (read_done) r_pend_done <= 1'b1;
                    if (read_next_line) r_pend_line <= 1'b1;
                    if (read_next_chunk) r_pend_chunk <= 1'b1;
                    if (!start) r_pend_abort <= 1'b1;
                    if (req_ready) begin
                        r_issued  <= r_issued + 16'd1;
                        r_credits <= r_credits - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_read_scheduler.sv
// Directed scoreboard bench for hdmi_read_scheduler (RGB888X and RGB565).
module tb_hdmi_read_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start, start2;
    logic [31:0] frame_base;
    logic [15:0] line_stride;
    logic [10:0] hres, hres2;
    logic        read_go, read_go2;
    logic        read_next_line, read_next_chunk, read_done;
    logic [9:0]  fifo_words;
    logic        req_ready;

    logic        vld0, busy0, und0;
    logic [31:0] addr0;
    logic [8:0]  len0;
    logic [10:0] idx0;
    logic        vld1, busy1, und1;
    logic [31:0] addr1;
    logic [8:0]  len1;
    logic [10:0] idx1;

    typedef struct packed {
        logic [31:0] addr;
        logic [8:0]  len;
    } req_t;

    req_t q0[$];
    req_t q1[$];
    int   n_assert;
    int   n_fail;

    localparam logic [31:0] BASE = 32'h1000_0000;

    hdmi_read_scheduler u_dut (
        .clock(clk), .reset_n(rst_n), .start(start),
        .frame_base(frame_base), .line_stride(line_stride), .hres(hres),
        .read_go(read_go), .read_next_line(read_next_line),
        .read_next_chunk(read_next_chunk), .read_done(read_done),
        .fifo_words(fifo_words), .req_valid(vld0), .req_ready(req_ready),
        .req_addr(addr0), .req_len(len0), .busy(busy0),
        .line_index(idx0), .line_underrun(und0)
    );

    hdmi_read_scheduler #(.NUM_BYTES_PER_PIXEL(2)) u_dut565 (
        .clock(clk), .reset_n(rst_n), .start(start2),
        .frame_base(frame_base), .line_stride(line_stride), .hres(hres2),
        .read_go(read_go2), .read_next_line(read_next_line),
        .read_next_chunk(read_next_chunk), .read_done(read_done),
        .fifo_words(fifo_words), .req_valid(vld1), .req_ready(req_ready),
        .req_addr(addr1), .req_len(len1), .busy(busy1),
        .line_index(idx1), .line_underrun(und1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void exp0(input logic [31:0] a, input logic [8:0] l);
        q0.push_back('{addr: a, len: l});
    endfunction

    function automatic void exp1(input logic [31:0] a, input logic [8:0] l);
        q1.push_back('{addr: a, len: l});
    endfunction

    task automatic pulse_chunk();
        read_next_chunk = 1'b1;
        tick(1);
        read_next_chunk = 1'b0;
        tick(3);
    endtask

    task automatic pulse_line();
        read_next_line = 1'b1;
        tick(1);
        read_next_line = 1'b0;
        tick(3);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
            tick(1);
            k++;
        end
        tick(8);
        check(tag, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic wait_valid0(input string tag);
        int k;
        k = 0;
        while (!vld0 && k < 50) begin
            tick(1);
            k++;
        end
        check(tag, 64'(vld0), 64'd1);
    endtask

    // Completed handshakes are popped from the scoreboard and compared.
    always @(negedge clk) begin
        req_t e;
        if (rst_n && req_ready && vld0) begin
            check("req0_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("req0_addr", 64'(addr0), 64'(e.addr));
                check("req0_len", 64'(len0), 64'(e.len));
            end
        end
        if (rst_n && req_ready && vld1) begin
            check("req1_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("req1_addr", 64'(addr1), 64'(e.addr));
                check("req1_len", 64'(len1), 64'(e.len));
            end
        end
    end

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        frame_base = BASE;
        line_stride = 16'd2560;
        hres = 11'd640;
        hres2 = 11'd0;
        read_go = 1'b0;
        read_go2 = 1'b0;
        read_next_line = 1'b0;
        read_next_chunk = 1'b0;
        read_done = 1'b0;
        fifo_words = '0;
        req_ready = 1'b1;
        tick(3);
        check("rst_valid", 64'(vld0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_addr", 64'(addr0), 64'd0);
        check("rst_len", 64'(len0), 64'd0);
        check("rst_index", 64'(idx0), 64'd0);
        check("rst_underrun", 64'(und0), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic line: two prefetch bursts then eight credited bursts.
        start = 1'b1;
        exp0(BASE, 9'd256);
        exp0(BASE + 32'h100, 9'd256);
        read_go = 1'b1;
        tick(1);
        read_go = 1'b0;
        check("go_latency", 64'(vld0), 64'd0);
        drain("prefetch_drain");
        check("busy_active", 64'(busy0), 64'd1);
        for (int i = 2; i < 10; i++) begin
            exp0(BASE + 32'(i * 256), 9'd256);
            pulse_chunk();
        end
        drain("chunks_drain");
        pulse_chunk();
        drain("extra_chunk_none");
        check("extra_chunk_valid", 64'(vld0), 64'd0);
        check("line0_underrun", 64'(und0), 64'd0);

        // Full line then advance.
        exp0(BASE + 32'd2560, 9'd256);
        exp0(BASE + 32'd2560 + 32'h100, 9'd256);
        pulse_line();
        drain("line1_prefetch");
        check("line1_index", 64'(idx0), 64'd1);
        check("line1_underrun", 64'(und0), 64'd0);

        // Advance after only five bursts.
        for (int i = 2; i < 5; i++) begin
            exp0(BASE + 32'd2560 + 32'(i * 256), 9'd256);
            pulse_chunk();
        end
        drain("line1_five");
        exp0(BASE + 32'd5120, 9'd256);
        exp0(BASE + 32'd5120 + 32'h100, 9'd256);
        pulse_line();
        drain("line2_prefetch");
        check("line2_underrun", 64'(und0), 64'd1);
        check("line2_index", 64'(idx0), 64'd2);

        // Line and chunk in the same cycle: chunk dropped, credits=2.
        exp0(BASE + 32'd7680, 9'd256);
        exp0(BASE + 32'd7680 + 32'h100, 9'd256);
        read_next_line = 1'b1;
        read_next_chunk = 1'b1;
        tick(1);
        read_next_line = 1'b0;
        read_next_chunk = 1'b0;
        drain("collision_two_only");
        check("line3_index", 64'(idx0), 64'd3);

        // Backpressure: request held stable while not ready.
        req_ready = 1'b0;
        exp0(BASE + 32'd7680 + 32'h200, 9'd256);
        pulse_chunk();
        wait_valid0("bp_valid_rise");
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(vld0), 64'd1);
            check("bp_addr", 64'(addr0), 64'(BASE + 32'd7680 + 32'h200));
            check("bp_len", 64'(len0), 64'd256);
            tick(1);
        end
        req_ready = 1'b1;
        drain("bp_drain");

        // FIFO space throttling at 32 free words, released at 64.
        fifo_words = 10'd480;
        exp0(BASE + 32'd7680 + 32'h300, 9'd256);
        pulse_chunk();
        tick(10);
        check("space_blocked", 64'(vld0), 64'd0);
        check("space_pending", 64'(q0.size()), 64'd1);
        fifo_words = 10'd448;
        drain("space_release");

        // Frame done, then 800-pixel frame with a short last burst.
        read_done = 1'b1;
        tick(1);
        read_done = 1'b0;
        tick(2);
        check("done_busy", 64'(busy0), 64'd0);
        hres = 11'd800;
        exp0(BASE, 9'd256);
        exp0(BASE + 32'h100, 9'd256);
        read_go = 1'b1;
        tick(1);
        read_go = 1'b0;
        drain("f2_prefetch");
        check("f2_underrun_clr", 64'(und0), 64'd0);
        check("f2_index_clr", 64'(idx0), 64'd0);
        for (int i = 2; i < 13; i++) begin
            exp0(BASE + 32'(i * 256), (i == 12) ? 9'd128 : 9'd256);
            pulse_chunk();
        end
        drain("f2_partial");

        // Start dropped while a request waits for ready.
        req_ready = 1'b0;
        exp0(BASE + 32'd2560, 9'd256);
        pulse_line();
        wait_valid0("abort_valid");
        start = 1'b0;
        tick(3);
        check("abort_hold_busy", 64'(busy0), 64'd1);
        check("abort_hold_valid", 64'(vld0), 64'd1);
        req_ready = 1'b1;
        tick(3);
        check("abort_idle_busy", 64'(busy0), 64'd0);
        drain("abort_drain");

        // Asynchronous reset while a request is pending.
        start = 1'b1;
        req_ready = 1'b0;
        hres = 11'd640;
        read_go = 1'b1;
        tick(1);
        read_go = 1'b0;
        wait_valid0("areset_valid");
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid_low", 64'(vld0), 64'd0);
        check("areset_busy_low", 64'(busy0), 64'd0);
        tick(2);
        rst_n = 1'b1;
        start = 1'b0;
        req_ready = 1'b1;
        tick(2);

        // RGB565 instance: 1280 pixels -> ten 256-byte bursts.
        frame_base = 32'h2000_0000;
        hres2 = 11'd1280;
        start2 = 1'b1;
        exp1(32'h2000_0000, 9'd256);
        exp1(32'h2000_0100, 9'd256);
        read_go2 = 1'b1;
        tick(1);
        read_go2 = 1'b0;
        drain("rgb565_prefetch");
        for (int i = 2; i < 10; i++) begin
            exp1(32'h2000_0000 + 32'(i * 256), 9'd256);
            pulse_chunk();
        end
        pulse_chunk();
        drain("rgb565_line");
        check("rgb565_underrun", 64'(und1), 64'd0);
        check("main_idle", 64'(busy0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
